// File: rtl/md_sched_if.sv
// E-stage MD hazard interface: decoded instruction flags in, issue/stall/status and perf counters out.
interface md_sched_if;
    logic        valid_E;
    logic        op_mul_E;
    logic        op_div_E;
    logic        divz_E;
    logic        op_mf_E;
    logic        op_mt_E;
    logic        exc_pending;
    logic        stall_ext;
    logic        en_md;
    logic        stall_md;
    logic        busy;
    logic        done;
    logic [31:0] issue_cnt;
    logic [31:0] stall_cyc;

    modport master (
        output valid_E, op_mul_E, op_div_E, divz_E, op_mf_E, op_mt_E, exc_pending, stall_ext,
        input  en_md, stall_md, busy, done, issue_cnt, stall_cyc
    );

    modport slave (
        input  valid_E, op_mul_E, op_div_E, divz_E, op_mf_E, op_mt_E, exc_pending, stall_ext,
        output en_md, stall_md, busy, done, issue_cnt, stall_cyc
    );
endinterface

// File: rtl/md_sched.sv
// Multiply-divide issue/hazard scheduler: mirrors the MDU latency countdown and stalls E
// while HI/LO is being produced; also counts MD issues and MD stall cycles.
module md_sched #(
    parameter int unsigned MULT_DELAY = 5,
    parameter int unsigned DIV_DELAY  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  md
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COMMIT
    } state_e;

    localparam logic [6:0] MULT_LAT = 7'(MULT_DELAY);
    localparam logic [6:0] DIV_LAT  = 7'(DIV_DELAY);

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;

    logic md_op;
    logic is_div;
    logic gate;
    logic md_class;

    always_comb begin
        md_op    = md.valid_E & (md.op_mul_E | (md.op_div_E & ~md.divz_E));
        is_div   = md.op_div_E & ~md.divz_E;
        gate     = ~md.exc_pending & ~md.stall_ext;
        md_class = md.op_mul_E | md.op_div_E | md.op_mf_E | md.op_mt_E;

        state_d     = state_q;
        cnt_d       = cnt_q;
        issue_cnt_d = issue_cnt_q;
        stall_cyc_d = stall_cyc_q;

        md.en_md    = (state_q == S_IDLE) & gate & md.valid_E & (md_op | md.op_mt_E);
        // A zero-divisor div is still MD-class, so it waits behind an in-flight op.
        md.stall_md = md.valid_E & md_class & (state_q != S_IDLE);
        md.busy     = (state_q != S_IDLE);
        md.done     = (state_q == S_COMMIT);

        unique case (state_q)
            S_IDLE: begin
                if (md_op && gate) begin
                    cnt_d       = is_div ? DIV_LAT : MULT_LAT;
                    state_d     = (cnt_d == 7'd1) ? S_COMMIT : S_RUN;
                    issue_cnt_d = issue_cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 7'd1;
                if (cnt_d == 7'd1) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (md.stall_md) begin
            stall_cyc_d = stall_cyc_q + 32'd1;
        end

        md.issue_cnt = issue_cnt_q;
        md.stall_cyc = stall_cyc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            issue_cnt_q <= '0;
            stall_cyc_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed table, corner sequences, and randomized
// stimulus against a remaining-cycles reference model.
module tb_md_sched;

    localparam int MULT_D = 5;
    localparam int DIV_D  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_sched_if bus ();

    md_sched #(
        .MULT_DELAY(MULT_D),
        .DIV_DELAY (DIV_D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (bus)
    );

    typedef struct packed {
        logic rst_n;
        logic valid;
        logic mul;
        logic div;
        logic divz;
        logic mf;
        logic mt;
        logic exc;
        logic stl;
    } in_t;

    typedef struct {
        in_t         i;
        logic        en;
        logic        st;
        logic        bz;
        logic        dn;
        logic [31:0] ic;
        logic [31:0] sc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model: cycles left until HI/LO is free (0 = nothing in flight).
    int          m_rem;
    logic [31:0] m_issue;
    logic [31:0] m_stall;
    logic        m_en, m_st, m_bz, m_dn, m_issue_now;
    in_t         cur;

    function automatic in_t vin(logic valid, logic mul, logic div, logic divz,
                                logic mf, logic mt, logic exc, logic stl);
        in_t r;
        r = '{rst_n: 1'b1, valid: valid, mul: mul, div: div, divz: divz,
              mf: mf, mt: mt, exc: exc, stl: stl};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, let the combinational outputs settle, and compare against the model.
    task automatic drive(input in_t v);
        logic md_op, gate;
        cur             = v;
        reset           = v.rst_n;
        bus.valid_E     = v.valid;
        bus.op_mul_E    = v.mul;
        bus.op_div_E    = v.div;
        bus.divz_E      = v.divz;
        bus.op_mf_E     = v.mf;
        bus.op_mt_E     = v.mt;
        bus.exc_pending = v.exc;
        bus.stall_ext   = v.stl;
        #1;
        md_op       = v.valid & (v.mul | (v.div & ~v.divz));
        gate        = ~v.exc & ~v.stl;
        m_bz        = (m_rem > 0);
        m_dn        = (m_rem == 1);
        m_en        = (m_rem == 0) & gate & v.valid & (md_op | v.mt);
        m_st        = v.valid & (v.mul | v.div | v.mf | v.mt) & (m_rem > 0);
        m_issue_now = (m_rem == 0) & md_op & gate;
        chk("en_md",     {31'd0, bus.en_md},    {31'd0, m_en});
        chk("stall_md",  {31'd0, bus.stall_md}, {31'd0, m_st});
        chk("busy",      {31'd0, bus.busy},     {31'd0, m_bz});
        chk("done",      {31'd0, bus.done},     {31'd0, m_dn});
        chk("issue_cnt", bus.issue_cnt, m_issue);
        chk("stall_cyc", bus.stall_cyc, m_stall);
    endtask

    // Advance the model across the coming rising edge and wait for the next falling edge.
    task automatic tick();
        if (!cur.rst_n) begin
            m_rem   = 0;
            m_issue = '0;
            m_stall = '0;
        end else begin
            if (m_st) m_stall = m_stall + 32'd1;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end else if (m_issue_now) begin
                m_rem   = (cur.div & ~cur.divz) ? DIV_D : MULT_D;
                m_issue = m_issue + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input in_t v);
        drive(v);
        tick();
    endtask

    vec_t tbl[11];
    in_t  idle_v, rst_v, r;

    initial begin
        m_rem   = 0;
        m_issue = '0;
        m_stall = '0;
        idle_v  = vin(0, 0, 0, 0, 0, 0, 0, 0);
        rst_v   = idle_v;
        rst_v.rst_n = 1'b0;

        // mult then dependent mfhi, zero-divisor div, real div, dependent divz/mt
        tbl[0]  = '{vin(1,1,0,0,0,0,0,0), 1, 0, 0, 0, 32'd0, 32'd0};
        tbl[1]  = '{vin(1,0,0,0,1,0,0,0), 0, 1, 1, 0, 32'd1, 32'd0};
        tbl[2]  = '{vin(1,0,0,0,1,0,0,0), 0, 1, 1, 0, 32'd1, 32'd1};
        tbl[3]  = '{vin(1,0,0,0,1,0,0,0), 0, 1, 1, 0, 32'd1, 32'd2};
        tbl[4]  = '{vin(1,0,0,0,1,0,0,0), 0, 1, 1, 0, 32'd1, 32'd3};
        tbl[5]  = '{vin(1,0,0,0,1,0,0,0), 0, 1, 1, 1, 32'd1, 32'd4};
        tbl[6]  = '{vin(1,0,0,0,1,0,0,0), 0, 0, 0, 0, 32'd1, 32'd5};
        tbl[7]  = '{vin(1,0,1,1,0,0,0,0), 0, 0, 0, 0, 32'd1, 32'd5};
        tbl[8]  = '{vin(1,0,1,0,0,0,0,0), 1, 0, 0, 0, 32'd1, 32'd5};
        tbl[9]  = '{vin(1,0,1,1,0,0,0,0), 0, 1, 1, 0, 32'd2, 32'd5};
        tbl[10] = '{vin(1,0,0,0,0,1,0,0), 0, 1, 1, 0, 32'd2, 32'd6};

        @(negedge clk);
        // Reset hold, then quiet cycles: everything stays zero.
        for (int k = 0; k < 3; k++) step(rst_v);
        for (int k = 0; k < 3; k++) begin
            drive(idle_v);
            chk("quiet_busy", {31'd0, bus.busy}, 32'd0);
            chk("quiet_cnt",  bus.issue_cnt | bus.stall_cyc, 32'd0);
            tick();
        end

        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].i);
            chk("tbl_en",    {31'd0, bus.en_md},    {31'd0, tbl[k].en});
            chk("tbl_stall", {31'd0, bus.stall_md}, {31'd0, tbl[k].st});
            chk("tbl_busy",  {31'd0, bus.busy},     {31'd0, tbl[k].bz});
            chk("tbl_done",  {31'd0, bus.done},     {31'd0, tbl[k].dn});
            chk("tbl_issue", bus.issue_cnt, tbl[k].ic);
            chk("tbl_scyc",  bus.stall_cyc, tbl[k].sc);
            tick();
        end
        for (int k = 0; k < 10; k++) step(idle_v);

        // mt in IDLE writes HI/LO but is not an issue.
        drive(vin(1,0,0,0,0,1,0,0));
        chk("mt_idle_en", {31'd0, bus.en_md}, 32'd1);
        tick();
        chk("mt_no_issue", bus.issue_cnt, 32'd2);

        // div blocked by exception or external stall in IDLE.
        drive(vin(1,0,1,0,0,0,1,0));
        chk("div_exc_en", {31'd0, bus.en_md}, 32'd0);
        tick();
        drive(vin(1,0,1,0,0,0,0,1));
        chk("div_stl_en", {31'd0, bus.en_md}, 32'd0);
        tick();
        drive(idle_v);
        chk("blocked_busy", {31'd0, bus.busy}, 32'd0);
        tick();

        // Exception at cycle 3 of an in-flight div: done still at cycle 10.
        step(vin(1,0,1,0,0,0,0,0));
        for (int k = 1; k <= 11; k++) begin
            drive(vin(0,0,0,0,0,0,(k == 3),0));
            chk("exc_mid_done", {31'd0, bus.done}, {31'd0, (k == DIV_D)});
            tick();
        end

        // Reset at cycle 4 of a div: back to idle, counters cleared, no done later.
        step(vin(1,0,1,0,0,0,0,0));
        for (int k = 1; k < 4; k++) step(idle_v);
        step(rst_v);
        drive(idle_v);
        chk("rst_mid_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_issue", bus.issue_cnt, 32'd0);
        chk("rst_mid_scyc",  bus.stall_cyc, 32'd0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(idle_v);
            chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
            tick();
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            r.rst_n = ($urandom % 80) != 0;
            r.valid = ($urandom % 4) != 0;
            r.mul   = ($urandom % 4) == 0;
            r.div   = ($urandom % 5) == 0;
            r.divz  = ($urandom % 3) == 0;
            r.mf    = ($urandom % 4) == 0;
            r.mt    = ($urandom % 5) == 0;
            r.exc   = ($urandom % 8) == 0;
            r.stl   = ($urandom % 6) == 0;
            step(r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_sched.md
# md_sched

Issue/hazard scheduler for the multiply-divide unit in pipeline stage E. It decides each cycle whether the E-stage instruction may start an MDU operation or write HI/LO, and it holds E while a previous MD operation is in flight. It mirrors the MDU's fixed-latency countdown, so HI/LO readers and writers never observe a half-finished result. It also keeps two wrap-around performance counters for MD issue and MD stall cycles.

## Interface
Parameters:
- `MULT_DELAY`, default 5: busy cycles for the mult/madd/msub class; legal range 1..127.
- `DIV_DELAY`, default 10: busy cycles for div/divu; legal range 1..127.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-low; `reset==0` at a rising edge resets all state.
- `valid_E`, in, 1: E holds a real instruction, not a bubble.
- `op_mul_E`, in, 1: mult, multu, madd, maddu, msub or msubu in E.
- `op_div_E`, in, 1: div or divu in E.
- `divz_E`, in, 1: divisor operand is zero; meaningful only with `op_div_E`.
- `op_mf_E`, in, 1: mfhi or mflo in E.
- `op_mt_E`, in, 1: mthi or mtlo in E.
- `exc_pending`, in, 1: an exception or interrupt flushes E this cycle.
- `stall_ext`, in, 1: E is held this cycle by another hazard source.
- `en_md`, out, 1: MDU may start, or HI/LO may be written, this cycle.
- `stall_md`, out, 1: hold E this cycle because of an MD hazard.
- `busy`, out, 1: an MD operation is in flight.
- `done`, out, 1: one-cycle pulse in the cycle HI/LO commits.
- `issue_cnt`, out, 32: count of MD operations issued.
- `stall_cyc`, out, 32: count of cycles with `stall_md==1`.

## Operation
- State machine with 3 states: IDLE, RUN, COMMIT. A 7-bit counter `cnt` is internal.
- Derived terms:
  - `md_op = valid_E & (op_mul_E | (op_div_E & ~divz_E))`
  - `gate = ~exc_pending & ~stall_ext`
- Issue happens when state is IDLE and `md_op & gate`. At the edge: `cnt <= DIV_DELAY` for a divide, otherwise `MULT_DELAY`. Next state is COMMIT if the loaded value is 1, otherwise RUN.
- RUN:
  - Each edge does `cnt <= cnt-1`.
  - When `cnt` becomes 1, state goes to COMMIT.
- COMMIT:
  - `done=1`.
  - The next edge goes to IDLE with `cnt=0`.
- `en_md = (state==IDLE) & gate & valid_E & (md_op | op_mt_E)`.
- `stall_md = valid_E & (op_mul_E | op_div_E | op_mf_E | op_mt_E) & (state!=IDLE)`.
  - This includes a div with zero divisor, which must not overtake an in-flight op.
- `busy = (state!=IDLE)`. The issue cycle itself does not stall, because the issuing instruction proceeds.
- Divide with `divz_E=1` in IDLE: no issue, `en_md=0`, HI/LO unchanged, the instruction proceeds, `issue_cnt` is unchanged.
- `exc_pending` during RUN/COMMIT: the in-flight op completes normally, because its instruction already left E. A new issue is suppressed.
- `exc_pending` or `stall_ext` in IDLE with `md_op`: no issue, no state change, `en_md=0`.
- `issue_cnt` increments by 1 on each issue edge. `stall_cyc` increments on each edge where `stall_md==1`. Both wrap from 0xFFFFFFFF to 0.

## Timing
- Reset values (any state, including mid-operation):
  - state IDLE, `cnt=0`, `issue_cnt=0`, `stall_cyc=0`.
  - Outputs `busy=0`, `done=0`, `stall_md=0`.
  - `en_md` follows its equation from IDLE.
- Issue in cycle t with delay D:
  - `busy=1` in cycles t+1 through t+D.
  - `done=1` in cycle t+D only.
  - Back to IDLE in cycle t+D+1.
  - This matches the MDU writing HI/LO at the end of cycle t+D.
- A dependent MD-class instruction arriving in E at cycle t+1 stalls for D cycles and proceeds, or issues, in cycle t+D+1.
- Back-to-back issue: the earliest next issue is t+D+1; there is no overlap.
- With D=1: RUN is skipped; COMMIT is in cycle t+1.
- All outputs except the counters are combinational from state and inputs. They have no registered delay.

## Test plan
- Reset hold, then `reset=1` with no stimulus: all outputs 0; counters stay 0.
- mult issued at cycle 0, mfhi in E from cycle 1: `en_md=1` at cycle 0; `busy` and `stall_md` high in cycles 1–5; `done` at cycle 5; mfhi proceeds at cycle 6; `stall_cyc=5`, `issue_cnt=1`.
- div with `divz_E=1` in IDLE: `en_md=0`, `busy` stays 0, `issue_cnt` unchanged. The same op while RUN (after a prior div) gives `stall_md=1`.
- div with `exc_pending=1` in IDLE gives no issue. `exc_pending` raised at cycle 3 of a DIV_DELAY=10 op: `done` still pulses at cycle 10.
- `reset=0` asserted at cycle 4 of a div: at cycle 5 state is IDLE, `busy=0`, counters 0, and no `done` pulse appears.
- Force `stall_cyc` to 0xFFFFFFFF via a long stall: one more stall edge gives 0.
